// File: rtl/simd_exec_ctrl.sv
// Sequencer for the multi-cycle SIMD vector unit in Execute: load, compute steps, done pulse.
// Optional RUN-cycle counter on SimdCycles is enabled by defining SIMD_CYCLE_CNT_EN.
module simd_exec_ctrl #(
    parameter int unsigned LAT_ADD = 2,
    parameter int unsigned LAT_MUL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SimdStartE,
    input  logic [1:0]  SimdOpE,
    input  logic        FlushE,
    output logic        SimdBusyE,
    output logic        SimdLoadE,
    output logic        SimdStepE,
    output logic        SimdDoneE,
    output logic [1:0]  SimdOpLatE,
    output logic [31:0] SimdCycles
);

    localparam int unsigned CntW = (LAT_MUL > 1) ? $clog2(LAT_MUL) : 1;
    localparam logic [CntW-1:0] AddCnt = CntW'(LAT_ADD - 1);
    localparam logic [CntW-1:0] MulCnt = CntW'(LAT_MUL - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e          stateQ;
    logic [CntW-1:0] cntQ;
    logic [1:0]      opLatQ;
    logic            busyQ;
    logic            loadQ;
    logic            stepQ;
    logic            doneQ;
    logic            accept;

    assign accept = (stateQ == StIdle) && SimdStartE && !FlushE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            opLatQ <= 2'b00;
            busyQ  <= 1'b0;
            loadQ  <= 1'b0;
            stepQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (accept) begin
                        stateQ <= StLoad;
                        opLatQ <= SimdOpE;
                        cntQ   <= SimdOpE[1] ? MulCnt : AddCnt;
                        busyQ  <= 1'b1;
                        loadQ  <= 1'b1;
                    end
                end
                StLoad: begin
                    loadQ <= 1'b0;
                    if (FlushE) begin
                        stateQ <= StIdle;
                        busyQ  <= 1'b0;
                    end else begin
                        stateQ <= StRun;
                        stepQ  <= 1'b1;
                    end
                end
                StRun: begin
                    if (FlushE) begin
                        stateQ <= StIdle;
                        busyQ  <= 1'b0;
                        stepQ  <= 1'b0;
                    end else if (cntQ == '0) begin
                        stateQ <= StDone;
                        busyQ  <= 1'b0;
                        stepQ  <= 1'b0;
                        doneQ  <= 1'b1;
                    end else begin
                        cntQ <= cntQ - 1'b1;
                    end
                end
                StDone: begin
                    // Flush here is the hazard unit's concern; done is still reported.
                    stateQ <= StIdle;
                    doneQ  <= 1'b0;
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    // The accept cycle stalls combinationally; gated by reset so outputs drop immediately.
    assign SimdBusyE  = busyQ || (accept && !reset);
    assign SimdLoadE  = loadQ;
    assign SimdStepE  = stepQ;
    assign SimdDoneE  = doneQ;
    assign SimdOpLatE = opLatQ;

`ifdef SIMD_CYCLE_CNT_EN
    logic [31:0] cyclesQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyclesQ <= 32'd0;
        end else if (stepQ && (cyclesQ != 32'hFFFF_FFFF)) begin
            cyclesQ <= cyclesQ + 32'd1;
        end
    end

    assign SimdCycles = cyclesQ;
`else
    assign SimdCycles = 32'd0;
`endif

endmodule

// File: tb/tb_simd_exec_ctrl.sv
// Bench for simd_exec_ctrl: directed timeline scenarios plus random traffic vs a timeline model.
module tb_simd_exec_ctrl;

    localparam int LatAdd = 2;
    localparam int LatMul = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SimdStartE = 1'b0;
    logic [1:0]  SimdOpE = 2'b00;
    logic        FlushE = 1'b0;
    logic        SimdBusyE, SimdLoadE, SimdStepE, SimdDoneE;
    logic [1:0]  SimdOpLatE;
    logic [31:0] SimdCycles;
    logic [37:0] actVec;

    simd_exec_ctrl #(.LAT_ADD(LatAdd), .LAT_MUL(LatMul)) dut (
        .clk(clk), .reset(reset), .SimdStartE(SimdStartE), .SimdOpE(SimdOpE), .FlushE(FlushE),
        .SimdBusyE(SimdBusyE), .SimdLoadE(SimdLoadE), .SimdStepE(SimdStepE),
        .SimdDoneE(SimdDoneE), .SimdOpLatE(SimdOpLatE), .SimdCycles(SimdCycles)
    );

    assign actVec = {SimdBusyE, SimdLoadE, SimdStepE, SimdDoneE, SimdOpLatE, SimdCycles};

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: an accepted instruction is tracked by its age k (cycles since accept).
    // k=1 load, k=2..L+1 compute, k=L+2 done.
    bit          mActive;
    int          mK;
    int          mL;
    logic [1:0]  mOpLat;
    logic [31:0] mCycles;

    function automatic void modelReset();
        mActive = 1'b0;
        mK      = 0;
        mL      = 0;
        mOpLat  = 2'b00;
        mCycles = 32'd0;
    endfunction

    function automatic logic [37:0] modelOut();
        logic b, l, s, d;
        logic [31:0] cyc;
        if (!mActive) begin
            b = SimdStartE && !FlushE && !reset;
            l = 1'b0; s = 1'b0; d = 1'b0;
        end else begin
            l = (mK == 1);
            s = (mK >= 2) && (mK <= mL + 1);
            d = (mK == mL + 2);
            b = (mK <= mL + 1);
        end
`ifdef SIMD_CYCLE_CNT_EN
        cyc = mCycles;
`else
        cyc = 32'd0;
`endif
        return {b, l, s, d, mOpLat, cyc};
    endfunction

    function automatic void modelTick();
        if (!mActive) begin
            if (SimdStartE && !FlushE) begin
                mActive = 1'b1;
                mK      = 1;
                mL      = SimdOpE[1] ? LatMul : LatAdd;
                mOpLat  = SimdOpE;
            end
        end else begin
            if (mK >= 2 && mK <= mL + 1 && mCycles != 32'hFFFF_FFFF) mCycles = mCycles + 1;
            if (mK == mL + 2) mActive = 1'b0;
            else if (FlushE) mActive = 1'b0;
            else mK = mK + 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        modelTick();
        #1;
    endtask

    task automatic test_reset();
        logic [37:0] exp;
        @(negedge clk);
        vectors++;
        if (actVec !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", actVec, 38'd0);
        end
        #1 reset = 1'b0;
        modelReset();
        // Launch a vmul and hit reset while it is in RUN, with StartE still high.
        SimdStartE = 1'b1; SimdOpE = 2'b10; FlushE = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (actVec !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_async got %h want %h", actVec, 38'd0);
        end
        @(posedge clk); #1;
        vectors++;
        if (actVec !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_held got %h want %h", actVec, 38'd0);
        end
        SimdStartE = 1'b0;
        reset = 1'b0;
        modelReset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp = modelOut();
            vectors++;
            if (actVec !== exp || SimdDoneE !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release c%0d got %h want %h", c, actVec, exp);
            end
            tick();
        end
    endtask

    task automatic test_vadd();
        logic [37:0] exp;
        for (int c = 0; c < 6; c++) begin
            SimdStartE = (c == 0); SimdOpE = 2'b00; FlushE = 1'b0;
            @(negedge clk);
            exp = modelOut();
            vectors++;
            if (actVec !== exp || SimdBusyE !== (c <= 3) || SimdLoadE !== (c == 1)
                || SimdStepE !== (c == 2 || c == 3) || SimdDoneE !== (c == 4)) begin
                miscompares++;
                $display("FAIL vadd c%0d got %h want %h", c, actVec, exp);
            end
            tick();
        end
    endtask

    task automatic test_vmac();
        logic [37:0] exp;
        for (int c = 0; c < 8; c++) begin
            SimdStartE = (c == 0); SimdOpE = 2'b11; FlushE = 1'b0;
            @(negedge clk);
            exp = modelOut();
            vectors++;
            if (actVec !== exp || SimdBusyE !== (c <= 5) || SimdStepE !== (c >= 2 && c <= 5)
                || SimdDoneE !== (c == 6) || (c >= 1 && SimdOpLatE !== 2'b11)) begin
                miscompares++;
                $display("FAIL vmac c%0d got %h want %h", c, actVec, exp);
            end
            tick();
        end
    endtask

    task automatic test_flush_run();
        logic [37:0] exp;
        for (int c = 0; c < 15; c++) begin
            SimdStartE = (c == 0); SimdOpE = 2'b10; FlushE = (c == 3);
            @(negedge clk);
            exp = modelOut();
            vectors++;
            if (actVec !== exp || SimdDoneE !== 1'b0 || (c >= 4 && SimdBusyE !== 1'b0)) begin
                miscompares++;
                $display("FAIL flush_run c%0d got %h want %h", c, actVec, exp);
            end
            tick();
        end
    endtask

    task automatic test_start_flush_idle();
        logic [37:0] exp;
        for (int c = 0; c < 5; c++) begin
            SimdStartE = 1'b1; SimdOpE = 2'(c); FlushE = 1'b1;
            @(negedge clk);
            exp = modelOut();
            vectors++;
            if (actVec !== exp || SimdBusyE !== 1'b0 || SimdLoadE !== 1'b0) begin
                miscompares++;
                $display("FAIL start_flush_idle c%0d got %h want %h", c, actVec, exp);
            end
            tick();
        end
        SimdStartE = 1'b0; FlushE = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [37:0] exp;
        logic [31:0] cycStart;
        int firstDone = -1;
        int secondLoad = -1;
        int loads = 0;
        cycStart = SimdCycles;
        for (int c = 0; c < 14; c++) begin
            SimdStartE = (c <= 5); SimdOpE = (c == 0) ? 2'b00 : 2'b01; FlushE = 1'b0;
            @(negedge clk);
            exp = modelOut();
            vectors++;
            if (actVec !== exp) begin
                miscompares++;
                $display("FAIL back_to_back c%0d got %h want %h", c, actVec, exp);
            end
            if (SimdDoneE === 1'b1 && firstDone < 0) firstDone = c;
            if (SimdLoadE === 1'b1) begin
                loads++;
                if (loads == 2) secondLoad = c;
            end
            tick();
        end
        vectors++;
        if (firstDone < 0 || secondLoad - firstDone != 2) begin
            miscompares++;
            $display("FAIL b2b_gap got done@%0d load@%0d want gap 2", firstDone, secondLoad);
        end
`ifdef SIMD_CYCLE_CNT_EN
        vectors++;
        if (SimdCycles - cycStart !== 32'd4) begin
            miscompares++;
            $display("FAIL b2b_cycles got %0d want 4", SimdCycles - cycStart);
        end
`endif
    endtask

    task automatic test_random();
        logic [37:0] exp;
        for (int c = 0; c < 400; c++) begin
            SimdStartE = ($urandom_range(2) != 0);
            SimdOpE    = 2'($urandom_range(3));
            FlushE     = ($urandom_range(7) == 0);
            @(negedge clk);
            exp = modelOut();
            vectors++;
            if (actVec !== exp || (SimdLoadE + SimdStepE + SimdDoneE) > 1) begin
                miscompares++;
                $display("FAIL random c%0d got %h want %h", c, actVec, exp);
            end
            tick();
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_vadd();
        test_vmac();
        test_flush_run();
        test_start_flush_idle();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
